// File: rtl/mmio_xbar.sv
// mmio_xbar: routes one MMIO master request at a time to NCH base/mask-decoded channels.
// Define MMIO_TIMEOUT_EN to end stalled ACCESS phases with an error after TIMEOUT cycles.
module mmio_xbar #(
  parameter int NCH = 4,
  parameter int DW = 32,
  parameter logic [NCH*32-1:0] BASES = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NCH*32-1:0] MASKS = {NCH{32'hFFFF_F000}},
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [31:0]       addr,
  input  logic [DW-1:0]     dtw,
  output logic [DW-1:0]     dtr,
  input  logic              rw,
  output logic              err,
  output logic [NCH-1:0]    s_valid,
  input  logic [NCH-1:0]    s_ready,
  output logic [31:0]       s_addr,
  output logic [DW-1:0]     s_dtw,
  output logic              s_rw,
  input  logic [NCH*DW-1:0] s_dtr
);
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t          state_q;
  logic            ready_q, err_q, s_rw_q, hit;
  logic [DW-1:0]   dtr_q, s_dtw_q;
  logic [NCH-1:0]  s_valid_q;
  logic [31:0]     s_addr_q;
  logic [SW-1:0]   sel_q, win;
`ifdef MMIO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q;
`endif
  // Scanning downwards lets the lowest matching channel win on overlapping windows.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if ((addr & MASKS[32*i+:32]) == BASES[32*i+:32]) begin
        hit = 1'b1;
        win = SW'(i);
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      dtr_q     <= '0;
      s_valid_q <= '0;
      s_addr_q  <= '0;
      s_dtw_q   <= '0;
      s_rw_q    <= 1'b0;
      sel_q     <= '0;
`ifdef MMIO_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (valid) begin
          s_dtw_q <= dtw;
          s_rw_q  <= rw;
          if (hit) begin
            sel_q     <= win;
            s_valid_q <= NCH'(1) << win;
            s_addr_q  <= addr & ~MASKS[32*win+:32];
            state_q   <= ACCESS;
`ifdef MMIO_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end else begin
            err_q   <= 1'b1;
            dtr_q   <= '0;
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        ACCESS: if (s_ready[sel_q]) begin
          dtr_q     <= s_rw_q ? '0 : s_dtr[DW*sel_q+:DW];
          err_q     <= 1'b0;
          s_valid_q <= '0;
          ready_q   <= 1'b1;
          state_q   <= DONE;
        end
`ifdef MMIO_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT)) begin
          dtr_q     <= '0;
          err_q     <= 1'b1;
          s_valid_q <= '0;
          ready_q   <= 1'b1;
          state_q   <= DONE;
        end else cnt_q <= cnt_q + 1'b1;
`endif
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign ready   = ready_q;
  assign err     = err_q;
  assign dtr     = dtr_q;
  assign s_valid = s_valid_q;
  assign s_addr  = s_addr_q;
  assign s_dtw   = s_dtw_q;
  assign s_rw    = s_rw_q;
endmodule
